// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - QPSK frame constants, modulator state encoding and symbol sign mapping
package qpsk_pkg;

   localparam int CLK_PER_SAMPLE  = 4;
   localparam int SAMPLES_PER_SYM = 32;
   localparam int SYMS_PER_FRAME  = 32;
   localparam int GAP_SAMPLES     = 64;
   localparam int SAMPLE_W        = 9;
   localparam int ACC_W           = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } mod_state_e;

   typedef struct packed {
      logic i_neg;
      logic q_neg;
   } sym_signs_t;

   // Receiver decides sym[0] = (I > 0) and sym[1] = (Q < 0); this is the inverse.
   function automatic sym_signs_t sym_to_signs(input logic [1:0] sym);
      sym_signs_t s;
      s.i_neg = ~sym[0];
      s.q_neg = sym[1];
      return s;
   endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// rtl/sample_strobe_gen.sv - clocks-per-sample divider producing the sample strobe
module sample_strobe_gen
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic strobe
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] div_q, div_d;

   always_comb begin
      div_d = div_q + 1'b1;
      if (clear || div_q == LAST) begin
         div_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign strobe = !clear && (div_q == LAST);

endmodule

// File: rtl/modulation.sv
// rtl/modulation.sv - QPSK transmit modulator: symbol holding register, frame FSM and sample datapath
module modulation
   import qpsk_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sym_in,
   input  logic       sym_valid,
   output logic       sym_ready,
   input  logic [8:0] GetSin,
   input  logic [8:0] GetCos,
   output logic [6:0] send_read,
   output logic [8:0] channel_in,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int SC_W = $clog2(SAMPLES_PER_SYM + 1);
   localparam int YC_W = $clog2(SYMS_PER_FRAME);
   localparam int GC_W = $clog2(GAP_SAMPLES);
   localparam logic [SC_W-1:0] FULL_SYM    = SC_W'(SAMPLES_PER_SYM);
   localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(SAMPLES_PER_SYM - 1);
   localparam logic [YC_W-1:0] LAST_SYM    = YC_W'(SYMS_PER_FRAME - 1);
   localparam logic [GC_W-1:0] LAST_GAP    = GC_W'(GAP_SAMPLES - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-255);

   mod_state_e          state_q, state_d;
   logic [1:0]          cur_sym_q, cur_sym_d, hold_sym_q, hold_sym_d, mod_sym;
   logic                hold_full_q, hold_full_d;
   logic [6:0]          send_read_q, send_read_d;
   logic [SC_W-1:0]     sample_cnt_q, sample_cnt_d;
   logic [YC_W-1:0]     symbol_cnt_q, symbol_cnt_d;
   logic [GC_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [SAMPLE_W-1:0] channel_in_q, channel_in_d, sample;
   logic                frame_done_q, frame_done_d, underrun_q, underrun_d;
   logic                strobe, accept, at_boundary, drain, bypass;
   sym_signs_t          signs;
   logic signed [ACC_W-1:0] sin_ext, cos_ext, acc, halved;

   assign accept      = sym_valid && !hold_full_q;
   assign at_boundary = (sample_cnt_q == FULL_SYM);

   sample_strobe_gen #(.DIV(CLK_PER_SAMPLE)) u_strobe (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == IDLE),
      .strobe (strobe)
   );

   // At a symbol boundary the strobe already emits the first sample of the next symbol.
   always_comb begin
      mod_sym = cur_sym_q;
      if (at_boundary) begin
         mod_sym = hold_full_q ? hold_sym_q : 2'b00;
      end
      signs   = sym_to_signs(mod_sym);
      sin_ext = {{(ACC_W - SAMPLE_W){GetSin[SAMPLE_W-1]}}, GetSin};
      cos_ext = {{(ACC_W - SAMPLE_W){GetCos[SAMPLE_W-1]}}, GetCos};
      acc     = (signs.i_neg ? -sin_ext : sin_ext) + (signs.q_neg ? -cos_ext : cos_ext);
      halved  = acc >>> 1;
      if (halved > SAT_MAX) begin
         sample = SAT_MAX[SAMPLE_W-1:0];
      end else if (halved < SAT_MIN) begin
         sample = SAT_MIN[SAMPLE_W-1:0];
      end else begin
         sample = halved[SAMPLE_W-1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_sym_d    = cur_sym_q;
      hold_sym_d   = hold_sym_q;
      hold_full_d  = hold_full_q;
      send_read_d  = send_read_q;
      sample_cnt_d = sample_cnt_q;
      symbol_cnt_d = symbol_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      channel_in_d = channel_in_q;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
      drain        = 1'b0;
      bypass       = 1'b0;
      case (state_q)
         IDLE: begin
            channel_in_d = '0;
            send_read_d  = '0;
            if (hold_full_q || sym_valid) begin
               state_d      = SEND;
               cur_sym_d    = hold_full_q ? hold_sym_q : sym_in;
               drain        = hold_full_q;
               bypass       = !hold_full_q;
               send_read_d  = 7'd1;
               sample_cnt_d = '0;
               symbol_cnt_d = '0;
            end
         end
         SEND: begin
            if (strobe) begin
               if (at_boundary && symbol_cnt_q == LAST_SYM) begin
                  state_d      = GAP;
                  channel_in_d = '0;
                  frame_done_d = 1'b1;
                  send_read_d  = '0;
                  gap_cnt_d    = '0;
               end else begin
                  channel_in_d = sample;
                  send_read_d  = (sample_cnt_q == LAST_SAMPLE) ? 7'd1 : send_read_q + 7'd1;
                  if (at_boundary) begin
                     cur_sym_d    = mod_sym;
                     drain        = hold_full_q;
                     underrun_d   = !hold_full_q;
                     symbol_cnt_d = symbol_cnt_q + 1'b1;
                     sample_cnt_d = SC_W'(1);
                  end else begin
                     sample_cnt_d = sample_cnt_q + 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (strobe) begin
               gap_cnt_d = gap_cnt_q + 1'b1;
               if (gap_cnt_q == LAST_GAP) begin
                  state_d   = IDLE;
                  gap_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A same-cycle accept lands after the drain, so the register stays full.
      if (drain) begin
         hold_full_d = 1'b0;
      end
      if (accept && !bypass) begin
         hold_full_d = 1'b1;
         hold_sym_d  = sym_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cur_sym_q    <= '0;
         hold_sym_q   <= '0;
         hold_full_q  <= 1'b0;
         send_read_q  <= '0;
         sample_cnt_q <= '0;
         symbol_cnt_q <= '0;
         gap_cnt_q    <= '0;
         channel_in_q <= '0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_sym_q    <= cur_sym_d;
         hold_sym_q   <= hold_sym_d;
         hold_full_q  <= hold_full_d;
         send_read_q  <= send_read_d;
         sample_cnt_q <= sample_cnt_d;
         symbol_cnt_q <= symbol_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         channel_in_q <= channel_in_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign sym_ready  = !hold_full_q;
   assign send_read  = send_read_q;
   assign channel_in = channel_in_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_modulation.sv
// tb/tb_modulation.sv - directed self-checking bench for the QPSK modulator
module tb_modulation;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;
   logic [8:0] GetSin;
   logic [8:0] GetCos;
   logic [6:0] send_read;
   logic [8:0] channel_in;
   logic       busy;
   logic       frame_done;
   logic       underrun;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   modulation dut (
      .clk        (clk),
      .reset      (reset),
      .sym_in     (sym_in),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .GetSin     (GetSin),
      .GetCos     (GetCos),
      .send_read  (send_read),
      .channel_in (channel_in),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      sym_valid = 1'b0;
      sym_in    = 2'b00;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Expected sample for each symbol with GetSin=100, GetCos=50.
   function automatic logic [8:0] exp_sample(input logic [1:0] s);
      case (s)
         2'b01:   return 9'h04B;
         2'b11:   return 9'h019;
         2'b10:   return 9'h1B5;
         default: return 9'h1E7;
      endcase
   endfunction

   function automatic logic [1:0] seq_sym(input int n);
      logic [1:0] lo, hi;
      lo = 2'(n);
      hi = 2'(n >> 2);
      return lo ^ hi;
   endfunction

   task automatic test_reset();
      reset     = 1'b0;
      sym_valid = 1'b0;
      sym_in    = 2'b00;
      GetSin    = 9'd100;
      GetCos    = 9'd50;
      tick();
      vectors++; if (channel_in !== 9'h000) begin miscompares++; $display("FAIL reset_channel_in: got %h expected 000", channel_in); end
      vectors++; if (send_read !== 7'd0) begin miscompares++; $display("FAIL reset_send_read: got %0d expected 0", send_read); end
      vectors++; if (sym_ready !== 1'b1) begin miscompares++; $display("FAIL reset_sym_ready: got %b expected 1", sym_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_sample_map(input string tag, input logic [1:0] s,
                                  input logic [8:0] sin_v, input logic [8:0] cos_v,
                                  input logic [8:0] expv);
      do_reset();
      GetSin    = sin_v;
      GetCos    = cos_v;
      sym_in    = s;
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      vectors++; if (busy !== 1'b1 || send_read !== 7'd1) begin miscompares++; $display("FAIL %s entry: got busy=%b send_read=%0d expected busy=1 send_read=1", tag, busy, send_read); end
      repeat (3) tick();
      vectors++; if (channel_in !== 9'h000) begin miscompares++; $display("FAIL %s latency: got %h expected 000", tag, channel_in); end
      tick();
      vectors++; if (channel_in !== expv || send_read !== 7'd2) begin miscompares++; $display("FAIL %s first_sample: got %h read=%0d expected %h read=2", tag, channel_in, send_read, expv); end
      repeat (3) tick();
      vectors++; if (channel_in !== expv) begin miscompares++; $display("FAIL %s hold: got %h expected %h", tag, channel_in, expv); end
   endtask

   task automatic test_underrun();
      logic [1:0] pat [0:4];
      logic [8:0] exp_k [0:6];
      int next_idx, un_cnt, un_c, fd_cnt, fd_c, gap_nz, bz_c, smp_bad;
      logic ready_b;
      pat = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
      exp_k = '{9'h04B, 9'h019, 9'h1B5, 9'h04B, 9'h019, 9'h1E7, 9'h1B5};
      un_cnt = 0; un_c = -1; fd_cnt = 0; fd_c = -1; gap_nz = 0; bz_c = -1; smp_bad = 0;
      do_reset();
      GetSin    = 9'd100;
      GetCos    = 9'd50;
      sym_in    = pat[0];
      sym_valid = 1'b1;
      tick();
      next_idx = 1;
      for (int c = 1; c <= 4360; c++) begin
         if (next_idx <= 31 && next_idx != 5) begin
            sym_valid = 1'b1;
            sym_in    = (next_idx < 5) ? pat[next_idx] : 2'(next_idx);
         end else begin
            sym_valid = 1'b0;
         end
         ready_b = sym_ready;
         tick();
         if (sym_valid && ready_b) next_idx++;
         if (underrun) begin
            un_cnt++;
            un_c = c;
            if (next_idx == 5) next_idx = 6;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_c = c;
         end
         if (fd_cnt > 0 && busy && channel_in !== 9'h000) gap_nz++;
         if (!busy && bz_c < 0) bz_c = c;
         for (int k = 0; k <= 6; k++) begin
            if (c == 4 * (32 * k + 1)) begin
               vectors++;
               if (channel_in !== exp_k[k]) begin
                  miscompares++;
                  $display("FAIL underrun_sym%0d: got %h expected %h", k, channel_in, exp_k[k]);
               end
            end
         end
      end
      sym_valid = 1'b0;
      vectors++; if (un_cnt !== 1) begin miscompares++; $display("FAIL underrun_count: got %0d expected 1", un_cnt); end
      vectors++; if (un_c !== 644) begin miscompares++; $display("FAIL underrun_cycle: got %0d expected 644", un_c); end
      vectors++; if (fd_cnt !== 1 || fd_c !== 4100) begin miscompares++; $display("FAIL underrun_frame_done: got count=%0d cycle=%0d expected 1 at 4100", fd_cnt, fd_c); end
      vectors++; if (gap_nz !== 0) begin miscompares++; $display("FAIL underrun_gap_zero: got %0d nonzero expected 0", gap_nz); end
      vectors++; if (bz_c !== 4356) begin miscompares++; $display("FAIL underrun_idle_cycle: got %0d expected 4356", bz_c); end
   endtask

   task automatic test_back_to_back();
      int acc_n, fd_cnt, un_cnt, gz, rel, base_n;
      int fd_c [0:1];
      logic ready_b;
      fd_cnt = 0; un_cnt = 0; gz = 0; fd_c[0] = -1; fd_c[1] = -1;
      do_reset();
      GetSin    = 9'd100;
      GetCos    = 9'd50;
      sym_valid = 1'b1;
      sym_in    = seq_sym(0);
      tick();
      acc_n = 1;
      for (int c = 1; c <= 8470; c++) begin
         sym_in  = seq_sym(acc_n);
         ready_b = sym_ready;
         tick();
         if (ready_b) acc_n++;
         if (c == 1) begin
            vectors++; if (sym_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_full: got %b expected 0", sym_ready); end
         end
         if (frame_done) begin
            if (fd_cnt < 2) fd_c[fd_cnt] = c;
            fd_cnt++;
         end
         if (underrun) un_cnt++;
         if (c >= 4100 && c <= 4360 && channel_in !== 9'h000) gz++;
         if (c == 4356) begin
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
         end
         if (c == 4357) begin
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart: got busy=%b expected 1", busy); end
         end
         rel    = (c <= 4356) ? c : c - 4357;
         base_n = (c <= 4356) ? 0 : 32;
         if (rel > 0 && rel < 4100 && rel % 128 == 4) begin
            vectors++;
            if (channel_in !== exp_sample(seq_sym(base_n + rel / 128))) begin
               miscompares++;
               $display("FAIL b2b_sym%0d: got %h expected %h", base_n + rel / 128, channel_in,
                        exp_sample(seq_sym(base_n + rel / 128)));
            end
         end
      end
      sym_valid = 1'b0;
      vectors++; if (fd_cnt !== 2 || fd_c[0] !== 4100 || fd_c[1] !== 8457) begin miscompares++; $display("FAIL b2b_frame_done: got count=%0d at %0d,%0d expected 2 at 4100,8457", fd_cnt, fd_c[0], fd_c[1]); end
      vectors++; if (un_cnt !== 0) begin miscompares++; $display("FAIL b2b_underrun: got %0d expected 0", un_cnt); end
      vectors++; if (gz !== 0) begin miscompares++; $display("FAIL b2b_gap_zero: got %0d nonzero expected 0", gz); end
   endtask

   task automatic test_reset_mid_send();
      int un_c;
      un_c = -1;
      do_reset();
      GetSin    = 9'd100;
      GetCos    = 9'd50;
      sym_in    = 2'b01;
      sym_valid = 1'b1;
      tick();
      sym_in = 2'b10;
      tick();
      sym_valid = 1'b0;
      repeat (700) tick();
      #2;
      reset = 1'b0;
      tick();
      vectors++; if (channel_in !== 9'h000 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_out: got ch=%h busy=%b expected 000 0", channel_in, busy); end
      vectors++; if (sym_ready !== 1'b1 || send_read !== 7'd0) begin miscompares++; $display("FAIL midreset_ready: got ready=%b read=%0d expected 1 0", sym_ready, send_read); end
      reset = 1'b1;
      tick();
      sym_in    = 2'b11;
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      vectors++; if (send_read !== 7'd1) begin miscompares++; $display("FAIL midreset_send_read: got %0d expected 1", send_read); end
      for (int c = 1; c <= 140; c++) begin
         tick();
         if (c == 4) begin
            vectors++; if (channel_in !== 9'h019) begin miscompares++; $display("FAIL midreset_first: got %h expected 019", channel_in); end
         end
         if (c == 132) begin
            vectors++; if (channel_in !== 9'h1E7) begin miscompares++; $display("FAIL midreset_filler: got %h expected 1e7", channel_in); end
         end
         if (underrun && un_c < 0) un_c = c;
      end
      vectors++; if (un_c !== 132) begin miscompares++; $display("FAIL midreset_underrun_cycle: got %0d expected 132", un_c); end
   endtask

   initial begin
      test_reset();
      test_sample_map("map01", 2'b01, 9'd100, 9'd50, 9'h04B);
      test_sample_map("map10", 2'b10, 9'd100, 9'd50, 9'h1B5);
      test_sample_map("map11", 2'b11, 9'd100, 9'd50, 9'h019);
      test_sample_map("map00", 2'b00, 9'd100, 9'd50, 9'h1E7);
      test_sample_map("sat01", 2'b01, 9'd255, 9'd255, 9'h0FF);
      test_sample_map("sat10", 2'b10, 9'd255, 9'd255, 9'h101);
      test_sample_map("clip_neg", 2'b01, 9'h100, 9'h100, 9'h101);
      test_sample_map("clip_pos", 2'b10, 9'h100, 9'h100, 9'h0FF);
      test_underrun();
      test_back_to_back();
      test_reset_mid_send();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
